// File: rtl/cv32e40p_trace_buffer.sv
// cv32e40p_trace_buffer: multi-hart retirement trace capture into a circular buffer
//   clk_i, rst_ni         : clock, asynchronous active-low reset
//   enable_i, clear_i     : capture enable, synchronous flush (highest priority)
//   retire_*_i            : per-hart retirement strobe, PC and instruction word
//   rd_*                  : valid/ready read port presenting the oldest entry
//   level_o/full_o/empty_o: occupancy; drop_cnt_o: saturating count of lost events
module cv32e40p_trace_buffer #(
  parameter int NUM_HARTS  = 2,
  parameter int DEPTH      = 16,
  parameter bit WRAP_MODE  = 1'b0,
  parameter int TS_W       = 16,
  parameter int DROP_CNT_W = 16,
  localparam int HART_W    = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1,
  localparam int LVL_W     = $clog2(DEPTH + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           enable_i,
  input  logic                           clear_i,
  input  logic [NUM_HARTS-1:0]           retire_valid_i,
  input  logic [NUM_HARTS-1:0][31:0]     retire_pc_i,
  input  logic [NUM_HARTS-1:0][31:0]     retire_instr_i,
  output logic                           rd_valid_o,
  input  logic                           rd_ready_i,
  output logic [HART_W-1:0]              rd_hart_o,
  output logic [31:0]                    rd_pc_o,
  output logic [31:0]                    rd_instr_o,
  output logic [TS_W-1:0]                rd_ts_o,
  output logic [LVL_W-1:0]               level_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [DROP_CNT_W-1:0]          drop_cnt_o
);
  localparam int AW = $clog2(DEPTH);

  logic [NUM_HARTS-1:0]           slot_v_q;
  logic [NUM_HARTS-1:0][31:0]     slot_pc_q, slot_instr_q;
  logic [NUM_HARTS-1:0][TS_W-1:0] slot_ts_q;
  logic [TS_W-1:0]                ts_q;
  logic [HART_W-1:0]              last_q, gnt_idx, idx;
  logic                           gnt_any, push, pop, overwrite;
  logic [NUM_HARTS-1:0]           gnt, load, drop;
  logic [LVL_W-1:0]               wp_q, rp_q;
  logic [DROP_CNT_W-1:0]          drop_q, drop_d;
  logic [DROP_CNT_W:0]            drop_sum;

  logic [HART_W-1:0] mem_hart  [DEPTH];
  logic [31:0]       mem_pc    [DEPTH];
  logic [31:0]       mem_instr [DEPTH];
  logic [TS_W-1:0]   mem_ts    [DEPTH];

  // Pointers carry one extra wrap bit, so their difference is the occupancy directly.
  assign level_o    = wp_q - rp_q;
  assign full_o     = level_o == LVL_W'(DEPTH);
  assign empty_o    = level_o == '0;
  assign rd_valid_o = ~empty_o;
  assign drop_cnt_o = drop_q;
  assign pop        = rd_valid_o & rd_ready_i;
  // A full buffer still takes an entry when a pop frees a slot or when wrapping.
  assign push       = gnt_any & (~full_o | pop | WRAP_MODE);
  assign overwrite  = push & full_o & ~pop;

  // Head fields are forced to zero while empty so that reset leaves all outputs at 0.
  assign rd_hart_o  = rd_valid_o ? mem_hart[rp_q[AW-1:0]]  : '0;
  assign rd_pc_o    = rd_valid_o ? mem_pc[rp_q[AW-1:0]]    : '0;
  assign rd_instr_o = rd_valid_o ? mem_instr[rp_q[AW-1:0]] : '0;
  assign rd_ts_o    = rd_valid_o ? mem_ts[rp_q[AW-1:0]]    : '0;

  // Round-robin search starting one past the last granted hart.
  always_comb begin
    gnt_idx = last_q;
    gnt_any = 1'b0;
    idx     = last_q;
    for (int i = 0; i < NUM_HARTS; i++) begin
      idx = (idx == HART_W'(NUM_HARTS - 1)) ? '0 : idx + 1'b1;
      if (slot_v_q[idx] && !gnt_any) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  // A granted slot frees up in the same cycle, so it can take a new retire back-to-back.
  always_comb begin
    drop_sum = {1'b0, drop_q} + (DROP_CNT_W + 1)'(overwrite);
    for (int h = 0; h < NUM_HARTS; h++) begin
      gnt[h]   = push && (gnt_idx == HART_W'(h));
      load[h]  = enable_i & retire_valid_i[h] & (~slot_v_q[h] | gnt[h]);
      drop[h]  = enable_i & retire_valid_i[h] & slot_v_q[h] & ~gnt[h];
      drop_sum = drop_sum + (DROP_CNT_W + 1)'(drop[h]);
    end
    drop_d = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_v_q     <= '0;
      slot_pc_q    <= '0;
      slot_instr_q <= '0;
      slot_ts_q    <= '0;
      ts_q         <= '0;
      last_q       <= HART_W'(NUM_HARTS - 1);
      wp_q         <= '0;
      rp_q         <= '0;
      drop_q       <= '0;
    end else if (clear_i) begin
      slot_v_q     <= '0;
      slot_pc_q    <= '0;
      slot_instr_q <= '0;
      slot_ts_q    <= '0;
      ts_q         <= '0;
      last_q       <= HART_W'(NUM_HARTS - 1);
      wp_q         <= '0;
      rp_q         <= '0;
      drop_q       <= '0;
    end else begin
      ts_q   <= ts_q + TS_W'(enable_i);
      drop_q <= drop_d;
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (load[h]) begin
          slot_v_q[h]     <= 1'b1;
          slot_pc_q[h]    <= retire_pc_i[h];
          slot_instr_q[h] <= retire_instr_i[h];
          slot_ts_q[h]    <= ts_q;
        end else if (gnt[h]) begin
          slot_v_q[h] <= 1'b0;
        end
      end
      if (push) begin
        wp_q   <= wp_q + 1'b1;
        last_q <= gnt_idx;
      end
      if (pop || overwrite) rp_q <= rp_q + 1'b1;
    end
  end

  // Storage carries no reset; entries are only observable between the read and write pointers.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_hart[wp_q[AW-1:0]]  <= gnt_idx;
      mem_pc[wp_q[AW-1:0]]    <= slot_pc_q[gnt_idx];
      mem_instr[wp_q[AW-1:0]] <= slot_instr_q[gnt_idx];
      mem_ts[wp_q[AW-1:0]]    <= slot_ts_q[gnt_idx];
    end
  end
endmodule

// File: tb/tb_cv32e40p_trace_buffer.sv
// tb_cv32e40p_trace_buffer: scoreboard bench driving a stop-mode and a wrap-mode buffer in parallel
module tb_cv32e40p_trace_buffer;
  typedef struct packed {
    logic [0:0]  hart;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [15:0] ts;
  } ent_t;

  logic             clk, rst_n, enable, clear, rd_ready;
  logic [1:0]       rv;
  logic [1:0][31:0] rpc, rin;
  logic             s_valid, w_valid, s_full, w_full, s_empty, w_empty;
  logic [0:0]       s_hart, w_hart;
  logic [31:0]      s_pc, w_pc, s_in, w_in;
  logic [15:0]      s_ts, w_ts, s_drop, w_drop;
  logic [2:0]       s_lvl, w_lvl;

  ent_t q_s[$];
  ent_t q_w[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  cv32e40p_trace_buffer #(.NUM_HARTS(2), .DEPTH(4), .WRAP_MODE(1'b0)) u_stop (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .clear_i(clear),
    .retire_valid_i(rv), .retire_pc_i(rpc), .retire_instr_i(rin),
    .rd_valid_o(s_valid), .rd_ready_i(rd_ready), .rd_hart_o(s_hart), .rd_pc_o(s_pc),
    .rd_instr_o(s_in), .rd_ts_o(s_ts), .level_o(s_lvl), .full_o(s_full),
    .empty_o(s_empty), .drop_cnt_o(s_drop));

  cv32e40p_trace_buffer #(.NUM_HARTS(2), .DEPTH(4), .WRAP_MODE(1'b1)) u_wrap (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .clear_i(clear),
    .retire_valid_i(rv), .retire_pc_i(rpc), .retire_instr_i(rin),
    .rd_valid_o(w_valid), .rd_ready_i(rd_ready), .rd_hart_o(w_hart), .rd_pc_o(w_pc),
    .rd_instr_o(w_in), .rd_ts_o(w_ts), .level_o(w_lvl), .full_o(w_full),
    .empty_o(w_empty), .drop_cnt_o(w_drop));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  function automatic ent_t mk(input logic h, input logic [31:0] pc, input logic [31:0] in, input logic [15:0] ts);
    return '{hart: h, pc: pc, instr: in, ts: ts};
  endfunction

  // Monitor: every accepted head entry is compared against the next expectation.
  always @(negedge clk) begin
    if (rst_n && s_valid && rd_ready) begin
      if (q_s.size() == 0) chk("stop_unexpected_pop", {s_hart, s_pc, s_in, s_ts}, '0);
      else chk("stop_entry", {s_hart, s_pc, s_in, s_ts}, q_s.pop_front());
    end
    if (rst_n && w_valid && rd_ready) begin
      if (q_w.size() == 0) chk("wrap_unexpected_pop", {w_hart, w_pc, w_in, w_ts}, '0);
      else chk("wrap_entry", {w_hart, w_pc, w_in, w_ts}, q_w.pop_front());
    end
  end

  int fh [9] = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
  int fc [9] = '{0, 0, 1, 2, 3, 4, 5, 6, 7};

  initial begin
    rst_n = 1'b1; enable = 1'b0; clear = 1'b0; rd_ready = 1'b0;
    rv = '0; rpc = '0; rin = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", {s_valid, w_valid}, 2'b00);
    chk("rst_empty", {s_empty, w_empty}, 2'b11);
    chk("rst_level", {s_lvl, w_lvl, s_full}, '0);
    chk("rst_drop_pc", {s_drop, w_drop, s_pc}, '0);
    step(2);
    rst_n = 1'b1; enable = 1'b1;
    // latency: retire in cycle 5, visible in cycle 7 with ts 5
    step(5);
    rv = 2'b01; rpc[0] = 32'h80; rin[0] = 32'h13;
    q_s.push_back(mk(1'b0, 32'h80, 32'h13, 16'd5));
    q_w.push_back(mk(1'b0, 32'h80, 32'h13, 16'd5));
    step();
    rv = '0;
    chk("lat_c6_valid", s_valid, 1'b0);
    step();
    chk("lat_c7_valid", {s_valid, w_valid}, 2'b11);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    chk("lat_empty_after_pop", {s_empty, w_empty}, 2'b11);
    // fairness: both harts retire cycles 0-7 with the consumer always ready
    do_clear();
    rd_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      q_s.push_back(mk(fh[i][0], 32'h1000 + 32'(fh[i]) * 32'h100 + 32'(fc[i]) * 4, 32'(fc[i]) + 32'(fh[i]) * 32'h10, 16'(fc[i])));
      q_w.push_back(mk(fh[i][0], 32'h1000 + 32'(fh[i]) * 32'h100 + 32'(fc[i]) * 4, 32'(fc[i]) + 32'(fh[i]) * 32'h10, 16'(fc[i])));
    end
    for (int k = 0; k < 8; k++) begin
      rv = 2'b11;
      rpc[0] = 32'h1000 + 32'(k) * 4; rin[0] = 32'(k);
      rpc[1] = 32'h1100 + 32'(k) * 4; rin[1] = 32'h10 + 32'(k);
      step();
    end
    rv = '0;
    step(6);
    chk("fair_drop", {s_drop, w_drop}, {16'd7, 16'd7});
    chk("fair_drained", {q_s.size() == 0, q_w.size() == 0, s_lvl}, {2'b11, 3'd0});
    // stop vs wrap: hart0 retires 0x00..0x14 with no consumer
    do_clear();
    rd_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      rv = 2'b01; rpc[0] = 32'(k) * 4; rin[0] = 32'h100 + 32'(k);
      if (k < 5) q_s.push_back(mk(1'b0, 32'(k) * 4, 32'h100 + 32'(k), 16'(k)));
      if (k >= 2) q_w.push_back(mk(1'b0, 32'(k) * 4, 32'h100 + 32'(k), 16'(k)));
      step();
    end
    rv = '0;
    step(2);
    chk("sw_full", {s_full, w_full}, 2'b11);
    chk("sw_level", {s_lvl, w_lvl}, {3'd4, 3'd4});
    chk("sw_drop", {s_drop, w_drop}, {16'd1, 16'd2});
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    chk("sw_level_after_pop", {s_lvl, s_full, w_lvl}, {3'd4, 1'b1, 3'd3});
    rd_ready = 1'b1;
    step(6);
    rd_ready = 1'b0;
    chk("sw_empty", {s_empty, w_empty, q_s.size() == 0, q_w.size() == 0}, 4'b1111);
    // clear: build backlog and drops, then flush with a concurrent hart1 retire
    do_clear();
    for (int k = 0; k < 10; k++) begin
      rv = 2'b01; rpc[0] = 32'h200 + 32'(k) * 4; rin[0] = 32'h300 + 32'(k);
      step();
    end
    rv = '0;
    step(2);
    chk("clr_pre_drop", {s_drop, w_drop}, {16'd5, 16'd6});
    q_s.push_back(mk(1'b0, 32'h200, 32'h300, 16'd0));
    q_s.push_back(mk(1'b0, 32'h204, 32'h301, 16'd1));
    q_w.push_back(mk(1'b0, 32'h218, 32'h306, 16'd6));
    q_w.push_back(mk(1'b0, 32'h21c, 32'h307, 16'd7));
    rd_ready = 1'b1;
    step(2);
    rd_ready = 1'b0;
    chk("clr_pre_level", {s_lvl, w_lvl}, {3'd3, 3'd2});
    clear = 1'b1; rv = 2'b10; rpc[1] = 32'hDEAD; rin[1] = 32'h1;
    step();
    clear = 1'b0; rv = '0;
    chk("clr_level", {s_lvl, w_lvl}, '0);
    chk("clr_flags", {s_empty, w_empty, s_valid, w_valid}, 4'b1100);
    chk("clr_drop", {s_drop, w_drop}, '0);
    rd_ready = 1'b1;
    step(4);
    rd_ready = 1'b0;
    chk("clr_no_ghost", {s_valid, w_valid, s_lvl}, '0);
    // async reset mid-cycle during a burst
    do_clear();
    for (int k = 0; k < 4; k++) begin
      rv = 2'b11; rpc[0] = 32'h500 + 32'(k); rpc[1] = 32'h600 + 32'(k); rin = '0;
      step();
    end
    rv = '0;
    chk("ar_pre_drop", {s_drop, w_drop}, {16'd3, 16'd3});
    #3 rst_n = 1'b0;
    #1;
    chk("ar_valid", {s_valid, w_valid}, 2'b00);
    chk("ar_level_empty", {s_lvl, w_lvl, s_empty, w_empty}, {6'd0, 2'b11});
    chk("ar_drop", {s_drop, w_drop}, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(2);
    rv = 2'b10; rpc[1] = 32'hABC; rin[1] = 32'h73;
    q_s.push_back(mk(1'b1, 32'hABC, 32'h73, 16'd2));
    q_w.push_back(mk(1'b1, 32'hABC, 32'h73, 16'd2));
    rd_ready = 1'b1;
    step();
    rv = '0;
    for (int i = 0; i < 20 && (q_s.size() != 0 || q_w.size() != 0); i++) step();
    chk("final_queues_empty", {32'(q_s.size()), 32'(q_w.size())}, '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
